// File: rtl/trb_busy_pkg.sv
// Shared types, defaults and helpers for the TRB busy responder.
package trb_busy_pkg;

  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned TAG_W_DEF     = 5;
  localparam int unsigned TMO_CNT_W_DEF = 8;
  localparam int unsigned ST_W          = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_LATCH   = 2'd1;
  localparam state_t ST_READOUT = 2'd2;
  localparam state_t ST_DEAD    = 2'd3;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_val;
    max_val = (32'd1 << w) - 32'd1;
    return (v >= max_val) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trb_busy_responder_if.sv
// Trigger/readout/busy bundle between the coincidence logic side and the TRB responder.
interface trb_busy_responder_if #(
  parameter int unsigned CNT_W     = trb_busy_pkg::CNT_W_DEF,
  parameter int unsigned TAG_W     = trb_busy_pkg::TAG_W_DEF,
  parameter int unsigned TMO_CNT_W = trb_busy_pkg::TMO_CNT_W_DEF
);
  import trb_busy_pkg::*;

  logic                 coincid_trg_in;
  logic [TAG_W-1:0]     coincid_tag_in;
  logic                 readout_done_in;
  logic                 busy_en_in;
  logic [CNT_W-1:0]     dead_time_in;
  logic [CNT_W-1:0]     readout_tmo_in;
  logic                 busy_a_out_N;
  logic                 busy_b_out_N;
  logic                 trg_accept_out;
  logic [TAG_W-1:0]     tag_out;
  logic [CNT_W-1:0]     trg_cnt_out;
  logic [CNT_W-1:0]     trg_lost_cnt_out;
  logic [TMO_CNT_W-1:0] tmo_cnt_out;
  state_t               state_out;

  modport slave (
    input  coincid_trg_in, coincid_tag_in, readout_done_in, busy_en_in,
           dead_time_in, readout_tmo_in,
    output busy_a_out_N, busy_b_out_N, trg_accept_out, tag_out,
           trg_cnt_out, trg_lost_cnt_out, tmo_cnt_out, state_out
  );

  modport master (
    output coincid_trg_in, coincid_tag_in, readout_done_in, busy_en_in,
           dead_time_in, readout_tmo_in,
    input  busy_a_out_N, busy_b_out_N, trg_accept_out, tag_out,
           trg_cnt_out, trg_lost_cnt_out, tmo_cnt_out, state_out
  );

endinterface

// File: rtl/trg_edge_sync.sv
// Rising-edge detect on the coincidence trigger with tag pass-through.
// TRB_TRG_SYNC_EN adds a 2-flop synchronizer on trigger and tag ahead of the edge detect.
module trg_edge_sync #(
  parameter int unsigned TAG_W = trb_busy_pkg::TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trg,
  input  logic [TAG_W-1:0] tag,
  output logic             rise_c,
  output logic [TAG_W-1:0] tag_c
);

`ifdef TRB_TRG_SYNC_EN
  logic             trg_s1, trg_s2, trg_q;
  logic [TAG_W-1:0] tag_s1, tag_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trg_s1 <= 1'b0;
      trg_s2 <= 1'b0;
      trg_q  <= 1'b0;
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      trg_s1 <= trg;
      trg_s2 <= trg_s1;
      trg_q  <= trg_s2;
      tag_s1 <= tag;
      tag_s2 <= tag_s1;
    end
  end

  assign rise_c = trg_s2 & ~trg_q;
  assign tag_c  = tag_s2;
`else
  logic trg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) trg_q <= 1'b0;
    else        trg_q <= trg;
  end

  assign rise_c = trg & ~trg_q;
  assign tag_c  = tag;
`endif

endmodule

// File: rtl/trb_busy_responder.sv
// TRB-side trigger responder: accepts coincidence triggers, holds busy through readout and dead time.
// TRB_TRG_SYNC_EN enables the input synchronizer inside trg_edge_sync.
module trb_busy_responder #(
  parameter int unsigned CNT_W     = trb_busy_pkg::CNT_W_DEF,
  parameter int unsigned TAG_W     = trb_busy_pkg::TAG_W_DEF,
  parameter int unsigned TMO_CNT_W = trb_busy_pkg::TMO_CNT_W_DEF
) (
  input logic                  clk_in,
  input logic                  rst_in_N,
  trb_busy_responder_if.slave  bus
);
  import trb_busy_pkg::*;

  state_t               state, state_nxt;
  logic                 trg_rise;
  logic [TAG_W-1:0]     tag_sync;
  logic [CNT_W-1:0]     timer, limit;
  logic                 tmo_hit;
  logic                 busy_n_nxt, accept_nxt;
  logic                 busy_n, accept;
  logic [TAG_W-1:0]     tag_q;
  logic [CNT_W-1:0]     trg_cnt, lost_cnt;
  logic [TMO_CNT_W-1:0] tmo_cnt;

  trg_edge_sync #(.TAG_W(TAG_W)) u_sync (
    .clk    (clk_in),
    .rst_n  (rst_in_N),
    .trg    (bus.coincid_trg_in),
    .tag    (bus.coincid_tag_in),
    .rise_c (trg_rise),
    .tag_c  (tag_sync)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in_N) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Done wins over a coinciding timeout; a zero limit disables the timeout.
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE:    if (trg_rise) state_nxt = ST_LATCH;
      ST_LATCH:   state_nxt = ST_READOUT;
      ST_READOUT: begin
        if (bus.readout_done_in) begin
          state_nxt = (bus.dead_time_in == '0) ? ST_IDLE : ST_DEAD;
        end else if (limit != '0 && timer == limit) begin
          tmo_hit   = 1'b1;
          state_nxt = (bus.dead_time_in == '0) ? ST_IDLE : ST_DEAD;
        end
      end
      ST_DEAD:    if (timer == limit) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_n_nxt = 1'b1;
    accept_nxt = 1'b0;
    if (state_nxt != ST_IDLE && bus.busy_en_in) busy_n_nxt = 1'b0;
    if (state_nxt == ST_LATCH)                  accept_nxt = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in_N) begin
      busy_n <= 1'b1;
      accept <= 1'b0;
    end else begin
      busy_n <= busy_n_nxt;
      accept <= accept_nxt;
    end
  end

  // Shared state timer: 1 in the first cycle of a state; limit captured on state entry.
  always_ff @(posedge clk_in) begin
    if (!rst_in_N) begin
      timer <= '0;
      limit <= '0;
    end else if (state_nxt != state) begin
      timer <= CNT_W'(1);
      if (state_nxt == ST_READOUT)   limit <= bus.readout_tmo_in;
      else if (state_nxt == ST_DEAD) limit <= bus.dead_time_in;
    end else if (state == ST_READOUT || state == ST_DEAD) begin
      timer <= timer + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in_N) begin
      tag_q    <= '0;
      trg_cnt  <= '0;
      lost_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (trg_rise) begin
        if (state == ST_IDLE) begin
          tag_q   <= tag_sync;
          trg_cnt <= CNT_W'(sat_inc(32'(trg_cnt), CNT_W));
        end else begin
          lost_cnt <= CNT_W'(sat_inc(32'(lost_cnt), CNT_W));
        end
      end
      if (tmo_hit) tmo_cnt <= TMO_CNT_W'(sat_inc(32'(tmo_cnt), TMO_CNT_W));
    end
  end

  assign bus.busy_a_out_N     = busy_n;
  assign bus.busy_b_out_N     = busy_n;
  assign bus.trg_accept_out   = accept;
  assign bus.tag_out          = tag_q;
  assign bus.trg_cnt_out      = trg_cnt;
  assign bus.trg_lost_cnt_out = lost_cnt;
  assign bus.tmo_cnt_out      = tmo_cnt;
  assign bus.state_out        = state;

endmodule

// File: tb/tb_trb_busy_responder.sv
// Scoreboard bench for trb_busy_responder: expected accepts and busy lengths are queued by stimulus.
module tb_trb_busy_responder;
  import trb_busy_pkg::*;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned TAG_W     = 5;
  localparam int unsigned TMO_CNT_W = 8;
`ifdef TRB_TRG_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] cnt;
  } acc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  trb_busy_responder_if #(.CNT_W(CNT_W), .TAG_W(TAG_W), .TMO_CNT_W(TMO_CNT_W)) bus ();

  trb_busy_responder #(.CNT_W(CNT_W), .TAG_W(TAG_W), .TMO_CNT_W(TMO_CNT_W)) dut (
    .clk_in   (clk),
    .rst_in_N (rst_n),
    .bus      (bus)
  );

  acc_t acc_q[$];
  int   busy_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT shows an accept or ends a busy period.
  acc_t acc_e;
  logic acc_prev   = 1'b0;
  int   busy_len   = 0;
  int   busy_bdiff = 0;
  int   busy_e;

  always @(negedge clk) begin
    if (bus.trg_accept_out === 1'b1) begin
      if (acc_prev) note_fail("accept_width");
      if (acc_q.size() == 0) begin
        note_fail("accept_unexpected");
      end else begin
        acc_e = acc_q.pop_front();
        check("accept_tag",   32'(bus.tag_out),     32'(acc_e.tag));
        check("accept_cnt",   32'(bus.trg_cnt_out), 32'(acc_e.cnt));
        check("accept_state", 32'(bus.state_out),   32'(ST_LATCH));
      end
    end
    acc_prev = (bus.trg_accept_out === 1'b1);

    if (bus.busy_a_out_N === 1'b0) begin
      busy_len++;
      if (bus.busy_b_out_N !== bus.busy_a_out_N) busy_bdiff++;
    end else if (busy_len > 0) begin
      if (busy_q.size() == 0) begin
        note_fail("busy_unexpected");
      end else begin
        busy_e = busy_q.pop_front();
        check("busy_len",  32'(busy_len),   32'(busy_e));
        check("busy_b_eq", 32'(busy_bdiff), 32'(0));
      end
      busy_len   = 0;
      busy_bdiff = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic expect_acc(input logic [TAG_W-1:0] tg, input logic [CNT_W-1:0] cnt);
    acc_t e;
    e.tag = tg;
    e.cnt = cnt;
    acc_q.push_back(e);
  endtask

  // Raise the trigger for width cycles; returns the cycle index of the accept (LATCH) cycle.
  task automatic fire(input logic [TAG_W-1:0] tg, input int width, output int acc_cyc);
    int lat;
    lat     = 0;
    acc_cyc = -1;
    bus.coincid_trg_in = 1'b1;
    bus.coincid_tag_in = tg;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == width) bus.coincid_trg_in = 1'b0;
      if (acc_cyc < 0 && bus.trg_accept_out === 1'b1) begin
        acc_cyc = cyc;
        lat     = i;
      end
      if (acc_cyc >= 0 && i >= width) break;
    end
    bus.coincid_trg_in = 1'b0;
    check("accept_latency", 32'(lat), 32'(1 + SYNC_LAT));
  endtask

  task automatic pulse(input logic [TAG_W-1:0] tg, input int width);
    bus.coincid_trg_in = 1'b1;
    bus.coincid_tag_in = tg;
    repeat (width) tick();
    bus.coincid_trg_in = 1'b0;
  endtask

  task automatic done_pulse();
    bus.readout_done_in = 1'b1;
    tick();
    bus.readout_done_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.state_out !== ST_IDLE && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) note_fail("idle_timeout");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    bus.coincid_trg_in  = 1'b0;
    bus.coincid_tag_in  = '0;
    bus.readout_done_in = 1'b0;
    bus.busy_en_in      = 1'b1;
    bus.dead_time_in    = '0;
    bus.readout_tmo_in  = '0;

    // Reset state
    repeat (3) tick();
    check("rst_state",  32'(bus.state_out),        32'(ST_IDLE));
    check("rst_busy_a", 32'(bus.busy_a_out_N),     32'(1));
    check("rst_busy_b", 32'(bus.busy_b_out_N),     32'(1));
    check("rst_accept", 32'(bus.trg_accept_out),   32'(0));
    check("rst_tag",    32'(bus.tag_out),          32'(0));
    check("rst_cnt",    32'(bus.trg_cnt_out),      32'(0));
    check("rst_lost",   32'(bus.trg_lost_cnt_out), 32'(0));
    check("rst_tmo",    32'(bus.tmo_cnt_out),      32'(0));
    rst_n = 1'b1;
    tick();

    // Dead 100, done 50 cycles after accept: busy 1+50+100; dead change inside DEAD ignored
    bus.dead_time_in = 16'd100;
    expect_acc(5'h13, 16'd1);
    busy_q.push_back(151);
    fire(5'h13, 2, a);
    wait_cyc(a + 50);
    done_pulse();
    wait_cyc(a + 60);
    bus.dead_time_in = 16'd7;
    wait_idle();
    repeat (3) tick();
    check("t1_cnt",  32'(bus.trg_cnt_out),      32'(1));
    check("t1_tag",  32'(bus.tag_out),          32'h13);
    check("t1_lost", 32'(bus.trg_lost_cnt_out), 32'(0));

    // Triggers during READOUT and DEAD are lost, tag unchanged
    bus.dead_time_in = 16'd30;
    expect_acc(5'h0A, 16'd2);
    busy_q.push_back(51);
    fire(5'h0A, 1, a);
    wait_cyc(a + 10);
    pulse(5'h1F, 3);
    wait_cyc(a + 20);
    done_pulse();
    wait_cyc(a + 30);
    check("t3_in_dead", 32'(bus.state_out), 32'(ST_DEAD));
    pulse(5'h1E, 3);
    wait_idle();
    repeat (3) tick();
    check("t3_lost", 32'(bus.trg_lost_cnt_out), 32'(2));
    check("t3_cnt",  32'(bus.trg_cnt_out),      32'(2));
    check("t3_tag",  32'(bus.tag_out),          32'h0A);

    // Timeout 20 with no done; level held high past IDLE gives no new edge
    bus.readout_tmo_in = 16'd20;
    bus.dead_time_in   = 16'd5;
    expect_acc(5'h07, 16'd3);
    busy_q.push_back(26);
    fire(5'h07, 40, a);
    wait_idle();
    repeat (3) tick();
    check("t4_tmo",  32'(bus.tmo_cnt_out),      32'(1));
    check("t4_lost", 32'(bus.trg_lost_cnt_out), 32'(2));
    check("t4_cnt",  32'(bus.trg_cnt_out),      32'(3));

    // Done and timeout on the same cycle count as done; dead 0 returns straight to IDLE
    bus.dead_time_in = 16'd0;
    expect_acc(5'h02, 16'd4);
    busy_q.push_back(21);
    fire(5'h02, 1, a);
    wait_cyc(a + 19);
    check("t4b_still_readout", 32'(bus.state_out), 32'(ST_READOUT));
    wait_cyc(a + 20);
    done_pulse();
    check("t4b_direct_idle", 32'(bus.state_out),   32'(ST_IDLE));
    check("t4b_tmo",         32'(bus.tmo_cnt_out), 32'(1));
    repeat (3) tick();

    // busy_en 0: busy lines stay high while the FSM walks 1,2,3,0
    bus.busy_en_in     = 1'b0;
    bus.dead_time_in   = 16'd3;
    bus.readout_tmo_in = 16'd0;
    expect_acc(5'h15, 16'd5);
    fire(5'h15, 1, a);
    check("t5_latch",  32'(bus.state_out),    32'(ST_LATCH));
    check("t5_busy_a", 32'(bus.busy_a_out_N), 32'(1));
    check("t5_busy_b", 32'(bus.busy_b_out_N), 32'(1));
    tick();
    check("t5_readout", 32'(bus.state_out), 32'(ST_READOUT));
    wait_cyc(a + 2);
    done_pulse();
    check("t5_dead", 32'(bus.state_out), 32'(ST_DEAD));
    wait_cyc(a + 5);
    check("t5_dead_last", 32'(bus.state_out), 32'(ST_DEAD));
    wait_cyc(a + 6);
    check("t5_idle", 32'(bus.state_out),   32'(ST_IDLE));
    check("t5_cnt",  32'(bus.trg_cnt_out), 32'(5));
    bus.busy_en_in = 1'b1;
    repeat (3) tick();

    // Reset while in DEAD aborts and clears counters
    bus.dead_time_in = 16'd100;
    expect_acc(5'h11, 16'd6);
    busy_q.push_back(21);
    fire(5'h11, 1, a);
    wait_cyc(a + 5);
    done_pulse();
    wait_cyc(a + 20);
    check("t6_pre_dead", 32'(bus.state_out), 32'(ST_DEAD));
    rst_n = 1'b0;
    tick();
    check("t6_state",  32'(bus.state_out),        32'(ST_IDLE));
    check("t6_busy_a", 32'(bus.busy_a_out_N),     32'(1));
    check("t6_cnt",    32'(bus.trg_cnt_out),      32'(0));
    check("t6_lost",   32'(bus.trg_lost_cnt_out), 32'(0));
    check("t6_tmo",    32'(bus.tmo_cnt_out),      32'(0));
    check("t6_tag",    32'(bus.tag_out),          32'(0));
    rst_n = 1'b1;
    tick();

    // Dead 0 after reset: READOUT -> IDLE directly
    bus.dead_time_in = 16'd0;
    expect_acc(5'h1C, 16'd1);
    busy_q.push_back(4);
    fire(5'h1C, 1, a);
    wait_cyc(a + 3);
    done_pulse();
    check("t6b_idle", 32'(bus.state_out), 32'(ST_IDLE));
    repeat (3) tick();

    // Timeout counter saturates at 255
    bus.readout_tmo_in = 16'd1;
    for (int i = 0; i < 257; i++) begin
      expect_acc(TAG_W'(i), CNT_W'(2 + i));
      busy_q.push_back(2);
      fire(TAG_W'(i), 1, a);
      wait_idle();
      repeat (3) tick();
    end
    check("sat_tmo", 32'(bus.tmo_cnt_out), 32'(255));
    check("sat_cnt", 32'(bus.trg_cnt_out), 32'(258));

    repeat (5) tick();
    check("acc_q_empty",  32'(acc_q.size()),  32'(0));
    check("busy_q_empty", 32'(busy_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
